// File: rtl/tessia_hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Forward-select helper gives M-stage priority over W-stage.
package tessia_hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_DRAIN,
    HZ_HALTED
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] REG_NOFWD = 4'hF;

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic       we_m,
    input logic [3:0] wa_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ra != REG_NOFWD) begin
      if (we_m && ra == wa_m) begin
        sel = FWD_MEM;
      end else if (we_w && ra == wa_w) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; active-low sync reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && q_q != '1) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard sequencer: forwarding, load-use stall,
// wrong-path flush, debug halt drain and perf counters.
module hazard_controller
  import tessia_hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchD,
  input  logic             BranchTakenE,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  hz_state_t     state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          drop_q, drop_d;
  logic          halt_ack_q, halt_ack_d;

  logic ldstall;
  logic pcpend;
  logic halt_ok;
  logic stall_inc;

  assign ldstall = MemToRegE && RegWriteE &&
                   (RA1D == WA3E || RA2D == WA3E);
  assign pcpend  = PCSrcD | PCSrcE | PCSrcM;
  assign halt_ok = !pcpend && !PCSrcW && !BranchD &&
                   !BranchTakenE && !ldstall;

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset) begin
      ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    drop_d  = drop_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        StallF = ldstall | pcpend;
        StallD = ldstall;
        FlushD = pcpend | PCSrcW | BranchTakenE;
        FlushE = ldstall | BranchTakenE;
        if (halt_req && halt_ok) begin
          state_d = HZ_DRAIN;
          drain_d = DRAIN_LOAD;
          drop_d  = 1'b0;
        end
      end
      HZ_DRAIN: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        // A released request still lets the bubbles finish
        if (!halt_req) begin
          drop_d = 1'b1;
        end
        if (drain_q == '0) begin
          state_d = drop_d ? HZ_RUN : HZ_HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      HZ_HALTED: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        if (!halt_req) begin
          state_d = HZ_RUN;
        end
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase
    halt_ack_d = (state_d == HZ_HALTED);
    if (!reset) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HZ_RUN;
      drain_q    <= '0;
      drop_q     <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      drop_q     <= drop_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  assign halt_ack  = halt_ack_q;
  assign stall_inc = (state_q == HZ_RUN) && ldstall;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (BranchTakenE),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: driver queues expected
// per-cycle outputs, a negedge monitor pops and compares.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemToRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic        BranchD, BranchTakenE, halt_req, cnt_clr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, halt_ack;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_controller #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchD(BranchD),
    .BranchTakenE(BranchTakenE), .halt_req(halt_req),
    .cnt_clr(cnt_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .halt_ack(halt_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [4:0]  ctl;
    logic        cc;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // ctl = {StallF, StallD, FlushD, FlushE, halt_ack}
  task automatic expect_out(input string nm, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [4:0] ctl,
                            input logic cc, input logic [15:0] sc,
                            input logic [15:0] fc);
    exp_t e;
    e.nm = nm; e.fa = fa; e.fb = fb; e.ctl = ctl;
    e.cc = cc; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e = q.pop_front();
      act = {StallF, StallD, FlushD, FlushE, halt_ack};
      checks++;
      if (ForwardAE !== e.fa || ForwardBE !== e.fb || act !== e.ctl ||
          (e.cc && (stall_cnt !== e.sc || flush_cnt !== e.fc))) begin
        errors++;
        $display("FAIL %s: got fa=%b fb=%b ctl=%b sc=%h fc=%h want fa=%b fb=%b ctl=%b sc=%h fc=%h (cnt %0d)",
                 e.nm, ForwardAE, ForwardBE, act, stall_cnt, flush_cnt,
                 e.fa, e.fb, e.ctl, e.sc, e.fc, e.cc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
    WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemToRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchD = 0; BranchTakenE = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; halt_req = 0; cnt_clr = 0;
    clr_in();
    tick();
    RegWriteM = 1; WA3M = 3; RA1E = 3; BranchTakenE = 1;
    expect_out("reset_outs", 2'b00, 2'b00, 5'b00110, 1, 16'd0, 16'd0);
    tick();
    reset = 1; BranchTakenE = 0;
    RegWriteW = 1; WA3W = 3;
    expect_out("fwd_a_mem", 2'b10, 2'b00, 5'b00000, 1, 16'd0, 16'd0);
    tick();
    RegWriteM = 0;
    expect_out("fwd_a_wb", 2'b01, 2'b00, 5'b00000, 0, 0, 0);
    tick();
    RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; RA2E = 15;
    expect_out("fwd_r15", 2'b00, 2'b00, 5'b00000, 0, 0, 0);
    tick();
    RA2E = 7; WA3W = 7;
    expect_out("fwd_b_wb", 2'b00, 2'b01, 5'b00000, 0, 0, 0);

    tick(); clr_in();
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    expect_out("ldstall", 2'b00, 2'b00, 5'b11010, 1, 16'd0, 16'd0);
    tick(); clr_in();
    expect_out("ldstall_cnt", 2'b00, 2'b00, 5'b00000, 1, 16'd1, 16'd0);

    tick(); PCSrcD = 1;
    expect_out("pc_d", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick(); PCSrcD = 0; PCSrcE = 1;
    expect_out("pc_e", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick(); PCSrcE = 0; PCSrcM = 1;
    expect_out("pc_m", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick(); PCSrcM = 0; PCSrcW = 1;
    expect_out("pc_w", 2'b00, 2'b00, 5'b00100, 0, 0, 0);
    tick(); PCSrcW = 0;
    expect_out("pc_done", 2'b00, 2'b00, 5'b00000, 0, 0, 0);

    tick(); BranchTakenE = 1;
    expect_out("br_taken", 2'b00, 2'b00, 5'b00110, 1, 16'd1, 16'd0);
    tick(); BranchTakenE = 0;
    expect_out("br_cnt", 2'b00, 2'b00, 5'b00000, 1, 16'd1, 16'd1);
    tick();
    BranchTakenE = 1; MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5;
    expect_out("ld_and_br", 2'b00, 2'b00, 5'b11110, 1, 16'd1, 16'd1);
    tick(); clr_in();
    expect_out("ld_br_cnt", 2'b00, 2'b00, 5'b00000, 1, 16'd2, 16'd2);

    tick(); halt_req = 1; BranchD = 1;
    expect_out("halt_blk", 2'b00, 2'b00, 5'b00000, 0, 0, 0);
    tick(); BranchD = 0;
    expect_out("halt_req", 2'b00, 2'b00, 5'b00000, 0, 0, 0);
    tick();
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5;
    expect_out("drain0", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick(); clr_in();
    expect_out("drain1", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick();
    expect_out("drain2", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick();
    expect_out("drain3", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick();
    expect_out("halted", 2'b00, 2'b00, 5'b10101, 0, 0, 0);
    tick(); halt_req = 0;
    expect_out("halted_rel", 2'b00, 2'b00, 5'b10101, 0, 0, 0);
    tick();
    expect_out("resume", 2'b00, 2'b00, 5'b00000, 1, 16'd2, 16'd2);

    tick(); halt_req = 1;
    expect_out("ab_req", 2'b00, 2'b00, 5'b00000, 0, 0, 0);
    tick(); halt_req = 0;
    expect_out("ab_d0", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick();
    expect_out("ab_d1", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick();
    expect_out("ab_d2", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick();
    expect_out("ab_d3", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick();
    expect_out("ab_run", 2'b00, 2'b00, 5'b00000, 0, 0, 0);

    tick(); halt_req = 1;
    expect_out("rs_req", 2'b00, 2'b00, 5'b00000, 0, 0, 0);
    tick();
    expect_out("rs_d0", 2'b00, 2'b00, 5'b10100, 0, 0, 0);
    tick(); reset = 0;
    expect_out("rs_mid", 2'b00, 2'b00, 5'b00110, 1, 16'd2, 16'd2);
    tick(); reset = 1; halt_req = 0;
    expect_out("rs_after", 2'b00, 2'b00, 5'b00000, 1, 16'd0, 16'd0);

    tick(); BranchTakenE = 1;
    repeat (65535) tick();
    expect_out("sat_full", 2'b00, 2'b00, 5'b00110, 1, 16'd0, 16'hFFFF);
    tick();
    expect_out("sat_hold", 2'b00, 2'b00, 5'b00110, 1, 16'd0, 16'hFFFF);
    tick(); cnt_clr = 1;
    expect_out("clr_pend", 2'b00, 2'b00, 5'b00110, 1, 16'd0, 16'hFFFF);
    tick(); cnt_clr = 0; BranchTakenE = 0;
    expect_out("clr_prio", 2'b00, 2'b00, 5'b00000, 1, 16'd0, 16'd0);
    tick();
    expect_out("clr_hold", 2'b00, 2'b00, 5'b00000, 1, 16'd0, 16'd0);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
